uart_tx_fsm: RTL and testbench
==============================

# uart_tx_fsm

Frame sequencer for the parameterized UART transmitter. It accepts a byte request and owns the frame state machine (IDLE, START, DATA, PARITY, STOP). It paces every bit on a baud tick, drives the serializer shift enable and the output-mux select, and raises `busy`. `busy` is the interlock the parity calculator and serializer use to latch input data only between frames.

## Interface
Parameters:
- `width`, default 8: data bits per frame; the bit counter is `$clog2(width)` bits wide.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `tick`, input, 1: baud enable; one-cycle pulse per bit period.
- `data_valid`, input, 1: transmit request; a level or pulse, sampled each `clk`.
- `parity_enable`, input, 1: insert a parity bit; sampled only at frame accept.
- `ser_en`, output, 1: serializer shift enable (Mealy output).
- `mux_sel`, output, 2: line source select.
  - 2'b00 = start (0).
  - 2'b01 = stop/idle (1).
  - 2'b10 = serial data.
  - 2'b11 = parity.
- `busy`, output, 1: frame in progress (registered).
- `frame_done`, output, 1: one-cycle pulse when the stop bit completes (registered).

## Operation
- States: IDLE, START, DATA, PARITY, STOP, with binary encoding.
- State outputs (Moore):
  - IDLE: `mux_sel` = 01, `busy` = 0.
  - START: `mux_sel` = 00, `busy` = 1.
  - DATA: `mux_sel` = 10, `busy` = 1.
  - PARITY: `mux_sel` = 11, `busy` = 1.
  - STOP: `mux_sel` = 01, `busy` = 1.
- IDLE:
  - `data_valid` = 1 moves to START.
  - On that edge, `parity_enable` is latched into `par_en_q`.
  - `tick` is ignored in IDLE.
- START: on `tick`, move to DATA and clear `bit_cnt` to 0.
- DATA:
  - On `tick` with `bit_cnt` < width-1: increment `bit_cnt` and stay in DATA.
  - On `tick` with `bit_cnt` = width-1: move to PARITY if `par_en_q` = 1, otherwise to STOP.
- PARITY: on `tick`, move to STOP.
- STOP: on `tick`, move to IDLE and assert `frame_done` for the following cycle.
- `ser_en` = (state == DATA) & `tick`. It is combinational and never asserted outside DATA.
  - It pulses exactly width times per frame; the last pulse coincides with leaving DATA.
- `data_valid` while `busy` = 1 is ignored. There is no queuing, and the request is lost unless the host holds it.
- `parity_enable` changes mid-frame have no effect on the current frame.
- Frame length in ticks:
  - 1 + width + 1 (no parity).
  - 1 + width + 2 (with parity).

## Timing
- Reset (`rst` = 0, asynchronous):
  - State = IDLE, `bit_cnt` = 0, `par_en_q` = 0.
  - `busy` = 0, `mux_sel` = 01, `frame_done` = 0, `ser_en` = 0.
- Reset asserted mid-frame:
  - Immediate return to IDLE; the line returns high (`mux_sel` = 01) with no stop bit.
  - No `frame_done` pulse.
- Accept latency:
  - `data_valid` sampled at edge N gives `busy` = 1 and `mux_sel` = 00 after edge N.
  - Downstream blocks latch data at edge N, because `busy` was still 0.
- Start bit length:
  - From accept until the first `tick` strictly after entering START.
  - A `tick` in the accept cycle does not end the start bit.
  - The start bit can therefore be shorter than one bit period; hosts align `data_valid` to `tick` when full start width is required.
- DATA, PARITY and STOP each last exactly one tick period. Transitions happen on the `clk` edge where `tick` = 1.
- `frame_done` is high for exactly one `clk`, the cycle after the STOP→IDLE edge, when `busy` is already 0.
- Back-to-back frames:
  - `data_valid` held high through STOP is accepted in the first IDLE cycle.
  - `busy` drops for exactly one cycle between frames.
- `tick` held high continuously is legal. Each `clk` then advances one bit, giving the minimum-length frame used in simulation.
- `width` = 1: DATA lasts exactly one tick; `bit_cnt` stays 0.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst` = 0, then release; no `data_valid`; 20 ticks.
  - Required: `mux_sel` = 01, `busy` = 0, `ser_en` = 0 and `frame_done` = 0 throughout.
- No-parity frame:
  - Stimulus: width = 8, `parity_enable` = 0, `tick` every 4 clks, 1-cycle `data_valid`.
  - Required: `mux_sel` sequence 00, then 10 for 8 ticks, then 01; exactly 8 `ser_en` pulses; 10 ticks from START to IDLE; one `frame_done`.
- Parity frame with mid-frame change:
  - Stimulus: `parity_enable` = 1 at accept, dropped to 0 during DATA.
  - Required: PARITY state (`mux_sel` = 11) still occurs for one tick; total 11 ticks.
- Request during busy:
  - Stimulus: `data_valid` pulses in START, in DATA bit 3, and in STOP.
  - Required: all pulses ignored; exactly one `frame_done`; state IDLE after STOP.
- Back-to-back frames:
  - Stimulus: `data_valid` held high, `tick` = 1 continuously, `parity_enable` = 0.
  - Required: `busy` low for exactly 1 cycle between frames; each frame is 10 clks of `busy`.
- Reset mid-frame:
  - Stimulus: assert `rst` at DATA bit 5, asynchronous to `clk`.
  - Required: `mux_sel` = 01 and `busy` = 0 immediately; no `frame_done`; the next frame after release is complete and correct.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: walks START, DATA, optional PARITY and STOP
// on baud ticks, driving the serializer shift enable, line mux select and busy.
module uart_tx_fsm #(
  parameter int width = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       data_valid,
  input  logic       parity_enable,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);

  // A 1-bit counter still exists for width == 1; it simply never leaves 0.
  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      par_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      par_en_q     <= par_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    par_en_d     = par_en_q;
    frame_done_d = 1'b0;
    ser_en       = 1'b0;
    unique case (state_q)
      // tick is deliberately ignored here so an accept-cycle tick cannot end START
      IDLE: begin
        if (data_valid) begin
          state_d  = START;
          par_en_d = parity_enable;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          ser_en = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    mux_sel = 2'b01;
    unique case (state_q)
      START:   mux_sel = 2'b00;
      DATA:    mux_sel = 2'b10;
      PARITY:  mux_sel = 2'b11;
      default: mux_sel = 2'b01;
    endcase
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: a queue of line symbols per frame serves as the
// reference; each scenario task drives randomized stimulus and checks inline.
module tb_uart_tx_fsm;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       data_valid = 1'b0;
  logic       parity_enable = 1'b0;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;
  logic       frame_done;
  logic [4:0] dut_vec;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_fsm #(.width(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .data_valid   (data_valid),
    .parity_enable(parity_enable),
    .ser_en       (ser_en),
    .mux_sel      (mux_sel),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  assign dut_vec = {ser_en, mux_sel, busy, frame_done};

  always #5 clk = ~clk;

  // Reference: remaining line symbols of the frame in flight (0 start, 2 data, 3 parity, 1 stop).
  int sym_q[$];
  bit m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (sym_q.size() == 0) begin
        if (data_valid) begin
          sym_q.push_back(0);
          repeat (WIDTH) sym_q.push_back(2);
          if (parity_enable) sym_q.push_back(3);
          sym_q.push_back(1);
        end
      end else if (tick) begin
        void'(sym_q.pop_front());
        if (sym_q.size() == 0) m_done = 1'b1;
      end
    end
  end

  function automatic int front();
    if (sym_q.size() == 0) return 1;
    return sym_q[0];
  endfunction

  function automatic int data_left();
    int n = 0;
    foreach (sym_q[k]) if (sym_q[k] == 2) n++;
    return n;
  endfunction

  function automatic logic [4:0] exp_out();
    logic       b;
    logic       s;
    logic [1:0] m;
    b = (sym_q.size() != 0);
    m = 2'(front());
    s = b && (front() == 2) && tick;
    return {s, m, b, m_done};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      tick = i[0];
      #1;
      n_chk++;
      if (dut_vec !== 5'b00100) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, dut_vec, 5'b00100);
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      tick = ((i % 4) == 3);
      #1;
      n_chk++;
      if (dut_vec !== 5'b00100 || dut_vec !== exp_out()) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, dut_vec, 5'b00100);
      end
    end
  endtask

  task automatic test_no_parity();
    int ser_cnt = 0, done_cnt = 0, busy_ticks = 0, seq = 1;
    logic [1:0] last_mux = 2'b01;
    int lead = $urandom_range(0, 3);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      data_valid = (i == lead);
      tick = ((i % 4) == 3);
      parity_enable = 1'b0;
      #1;
      n_chk++;
      if (dut_vec !== exp_out()) begin
        n_err++;
        $display("FAIL no_parity_cycle cyc=%0d got=%b want=%b", i, dut_vec, exp_out());
      end
      if (ser_en) ser_cnt++;
      if (frame_done) done_cnt++;
      if (busy && tick) busy_ticks++;
      if (mux_sel != last_mux) begin
        seq = seq * 4 + int'(mux_sel);
        last_mux = mux_sel;
      end
    end
    n_chk++;
    if (ser_cnt != WIDTH) begin
      n_err++;
      $display("FAIL no_parity_ser_en got=%0d want=%0d", ser_cnt, WIDTH);
    end
    n_chk++;
    if (busy_ticks != WIDTH + 2) begin
      n_err++;
      $display("FAIL no_parity_ticks got=%0d want=%0d", busy_ticks, WIDTH + 2);
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL no_parity_done got=%0d want=1", done_cnt);
    end
    // idle(01) -> start(00) -> data(10) -> stop(01), packed base 4
    n_chk++;
    if (seq != 73) begin
      n_err++;
      $display("FAIL no_parity_mux_seq got=%0d want=73", seq);
    end
  endtask

  task automatic test_parity_change();
    int done_cnt = 0, busy_ticks = 0, par_ticks = 0, seq = 1;
    logic [1:0] last_mux = 2'b01;
    bit dropped = 1'b0;
    int lead = $urandom_range(0, 3);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (front() == 2 && data_left() <= WIDTH - 2) dropped = 1'b1;
      data_valid = (i == lead);
      tick = ($urandom_range(0, 2) == 0);
      parity_enable = !dropped;
      #1;
      n_chk++;
      if (dut_vec !== exp_out()) begin
        n_err++;
        $display("FAIL parity_cycle cyc=%0d got=%b want=%b", i, dut_vec, exp_out());
      end
      if (frame_done) done_cnt++;
      if (busy && tick) busy_ticks++;
      if (mux_sel == 2'b11 && tick) par_ticks++;
      if (mux_sel != last_mux) begin
        seq = seq * 4 + int'(mux_sel);
        last_mux = mux_sel;
      end
    end
    parity_enable = 1'b0;
    n_chk++;
    if (busy_ticks != WIDTH + 3 || par_ticks != 1 || done_cnt != 1 || !dropped) begin
      n_err++;
      $display("FAIL parity_frame ticks=%0d par=%0d done=%0d dropped=%0d want 11/1/1/1",
               busy_ticks, par_ticks, done_cnt, dropped);
    end
    // idle -> start -> data -> parity(11) -> stop
    n_chk++;
    if (seq != 301) begin
      n_err++;
      $display("FAIL parity_mux_seq got=%0d want=301", seq);
    end
  endtask

  task automatic test_busy_requests();
    int done_cnt = 0, rises = 0, pulses = 0;
    bit p_start = 0, p_data = 0, p_stop = 0;
    logic prev_busy = 1'b0;
    int lead = $urandom_range(0, 2);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      data_valid = (i == lead);
      if (sym_q.size() != 0 && front() == 0 && !p_start) begin data_valid = 1; p_start = 1; end
      if (front() == 2 && data_left() == WIDTH - 3 && !p_data) begin data_valid = 1; p_data = 1; end
      if (sym_q.size() != 0 && front() == 1 && !p_stop) begin data_valid = 1; p_stop = 1; end
      if (data_valid) pulses++;
      tick = ((i % 3) == 2);
      parity_enable = $urandom_range(0, 1);
      #1;
      n_chk++;
      if (dut_vec !== exp_out()) begin
        n_err++;
        $display("FAIL busy_req_cycle cyc=%0d got=%b want=%b", i, dut_vec, exp_out());
      end
      if (frame_done) done_cnt++;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    data_valid = 1'b0;
    n_chk++;
    if (done_cnt != 1 || rises != 1 || pulses != 4 || busy !== 1'b0 || mux_sel !== 2'b01) begin
      n_err++;
      $display("FAIL busy_req done=%0d frames=%0d pulses=%0d busy=%b mux=%b want 1/1/4/0/01",
               done_cnt, rises, pulses, busy, mux_sel);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, hi_runs = 0, lo_runs = 0;
    logic prev_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      data_valid = (i < 40);
      tick = 1'b1;
      parity_enable = 1'b0;
      #1;
      n_chk++;
      if (dut_vec !== exp_out()) begin
        n_err++;
        $display("FAIL b2b_cycle cyc=%0d got=%b want=%b", i, dut_vec, exp_out());
      end
      if (i > 0 && busy != prev_busy) begin
        if (prev_busy) begin
          hi_runs++;
          n_chk++;
          if (run != WIDTH + 2) begin
            n_err++;
            $display("FAIL b2b_busy_len got=%0d want=%0d", run, WIDTH + 2);
          end
        end else if (hi_runs > 0) begin
          lo_runs++;
          n_chk++;
          if (run != 1) begin
            n_err++;
            $display("FAIL b2b_gap_len got=%0d want=1", run);
          end
        end
        run = 0;
      end
      run++;
      prev_busy = busy;
    end
    data_valid = 1'b0;
    tick = 1'b0;
    n_chk++;
    if (hi_runs != 4 || lo_runs != 3) begin
      n_err++;
      $display("FAIL b2b_frames got=%0d/%0d want=4/3", hi_runs, lo_runs);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0, busy_ticks = 0;
    bit hit = 1'b0;
    bit pe = 1'($urandom_range(0, 1));
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      data_valid = (i == 1);
      tick = (i[0] == 1'b1);
      parity_enable = pe;
      if (front() == 2 && data_left() == WIDTH - 5) begin
        hit = 1'b1;
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        n_chk++;
        if (dut_vec !== 5'b00100) begin
          n_err++;
          $display("FAIL reset_mid_immediate got=%b want=%b", dut_vec, 5'b00100);
        end
      end
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid_reach got=0 want=1");
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick = 1'b1;
      #1;
      n_chk++;
      if (dut_vec !== 5'b00100) begin
        n_err++;
        $display("FAIL reset_mid_hold cyc=%0d got=%b want=%b", i, dut_vec, 5'b00100);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      data_valid = (i == 2);
      tick = (i[0] == 1'b1);
      parity_enable = pe;
      #1;
      n_chk++;
      if (dut_vec !== exp_out()) begin
        n_err++;
        $display("FAIL reset_mid_next cyc=%0d got=%b want=%b", i, dut_vec, exp_out());
      end
      if (frame_done) done_cnt++;
      if (busy && tick) busy_ticks++;
    end
    n_chk++;
    if (done_cnt != 1 || busy_ticks != WIDTH + 2 + int'(pe)) begin
      n_err++;
      $display("FAIL reset_mid_frame done=%0d ticks=%0d want 1/%0d",
               done_cnt, busy_ticks, WIDTH + 2 + int'(pe));
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity_change();
    test_busy_requests();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
